// File: rtl/operand_bypass_if.sv
// Bundle of ID-stage operand request, pipeline result buses and resolved
// operand outputs for operand_bypass_mux.
//   master : ID/pipeline side; drives the request and forwarding sources
//   slave  : the bypass mux; returns stall_o, op_o and op_valid_o
interface operand_bypass_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned NUM_RD = 2
);
   logic                     id_valid_i;
   logic                     flush_i;
   logic [NUM_RD-1:0]        rd_use_i;
   logic [NUM_RD*REG_AW-1:0] rd_addr_i;
   logic [NUM_RD*DATA_W-1:0] rf_data_i;
   logic                     id_wen_i;
   logic [REG_AW-1:0]        id_dst_i;
   logic                     id_is_load_i;
   logic [DATA_W-1:0]        ex_result_i;
   logic [DATA_W-1:0]        mem_result_i;
   logic [DATA_W-1:0]        wb_data_i;
   logic                     stall_o;
   logic [NUM_RD*DATA_W-1:0] op_o;
   logic                     op_valid_o;

   modport master (
      output id_valid_i, flush_i, rd_use_i, rd_addr_i, rf_data_i,
             id_wen_i, id_dst_i, id_is_load_i,
             ex_result_i, mem_result_i, wb_data_i,
      input  stall_o, op_o, op_valid_o
   );

   modport slave (
      input  id_valid_i, flush_i, rd_use_i, rd_addr_i, rf_data_i,
             id_wen_i, id_dst_i, id_is_load_i,
             ex_result_i, mem_result_i, wb_data_i,
      output stall_o, op_o, op_valid_o
   );
endinterface

// File: rtl/operand_bypass_mux.sv
// ID/EX operand bypass: per read port picks EX result, MEM result, WB data
// or register-file data (youngest producer first), registers the operands
// into EX and raises a one-cycle load-use stall.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand_bypass_if slave (request, forwarding sources,
//                stall_o combinational, op_o/op_valid_o registered)
module operand_bypass_mux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned NUM_RD = 2
) (
   input logic              clk,
   input logic              rst_n,
   operand_bypass_if.slave  bus
);

   // Load flag is only consulted while the producer sits in EX; once it has
   // reached MEM the load data is on mem_result_i and forwards normally.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dst;
      logic              is_load;
   } ex_slot_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] dst;
   } fwd_slot_t;

   ex_slot_t                 ex_q, ex_d;
   fwd_slot_t                mem_q, wb_q;
   logic [NUM_RD*DATA_W-1:0] op_q;
   logic [NUM_RD*DATA_W-1:0] op_res_c;
   logic                     op_valid_q;
   logic [NUM_RD-1:0]        hazard_c;
   logic                     stall_c;
   logic                     issue_c;

   // Per-port resolution and load-use detection
   for (genvar k = 0; k < NUM_RD; k++) begin : g_port
      logic [REG_AW-1:0] addr;
      logic [DATA_W-1:0] res;
      logic              hit_ex, hit_mem, hit_wb;

      assign addr    = bus.rd_addr_i[k*REG_AW +: REG_AW];
      assign hit_ex  = ex_q.valid && (ex_q.dst == addr) && !ex_q.is_load;
      assign hit_mem = mem_q.valid && (mem_q.dst == addr);
      assign hit_wb  = wb_q.valid && (wb_q.dst == addr);

      assign res = (addr == '0) ? '0 :
                   hit_ex       ? bus.ex_result_i :
                   hit_mem      ? bus.mem_result_i :
                   hit_wb       ? bus.wb_data_i :
                                  bus.rf_data_i[k*DATA_W +: DATA_W];

      assign op_res_c[k*DATA_W +: DATA_W] = res;

      assign hazard_c[k] = bus.rd_use_i[k] && (addr != '0) && ex_q.valid &&
                           ex_q.is_load && (ex_q.dst == addr);
   end

   // Stall/issue decision and next EX slot; flush overrides both
   always_comb begin
      stall_c = 1'b0;
      issue_c = 1'b0;
      ex_d    = '0;
      if (bus.id_valid_i && !bus.flush_i) begin
         stall_c = |hazard_c;
         issue_c = !stall_c;
      end
      if (issue_c) begin
         ex_d.valid   = bus.id_wen_i && (bus.id_dst_i != '0);
         ex_d.dst     = bus.id_dst_i;
         ex_d.is_load = bus.id_is_load_i;
      end
   end

   // Scoreboard shift and operand register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q       <= '0;
         mem_q      <= '0;
         wb_q       <= '0;
         op_q       <= '0;
         op_valid_q <= 1'b0;
      end else begin
         ex_q       <= ex_d;
         mem_q      <= '{valid: ex_q.valid, dst: ex_q.dst};
         wb_q       <= mem_q;
         op_valid_q <= issue_c;
         if (issue_c) begin
            op_q <= op_res_c;
         end
      end
   end

   assign bus.stall_o    = stall_c;
   assign bus.op_o       = op_q;
   assign bus.op_valid_o = op_valid_q;

endmodule

// File: tb/tb_operand_bypass_mux.sv
// Bench for operand_bypass_mux: a 3-port and a 2-port instance share one
// stimulus stream (the 2-port one sees ports 0..1). Directed table, an
// async-reset-mid-stall sequence, then random traffic against an in-flight
// instruction history model.
module tb_operand_bypass_mux;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   operand_bypass_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_RD(3)) b3 ();
   operand_bypass_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_RD(2)) b2 ();

   assign b2.id_valid_i   = b3.id_valid_i;
   assign b2.flush_i      = b3.flush_i;
   assign b2.rd_use_i     = b3.rd_use_i[1:0];
   assign b2.rd_addr_i    = b3.rd_addr_i[2*REG_AW-1:0];
   assign b2.rf_data_i    = b3.rf_data_i[2*DATA_W-1:0];
   assign b2.id_wen_i     = b3.id_wen_i;
   assign b2.id_dst_i     = b3.id_dst_i;
   assign b2.id_is_load_i = b3.id_is_load_i;
   assign b2.ex_result_i  = b3.ex_result_i;
   assign b2.mem_result_i = b3.mem_result_i;
   assign b2.wb_data_i    = b3.wb_data_i;

   operand_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_RD(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(b3));
   operand_bypass_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_RD(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(b2));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- stimulus state ----------------
   bit          s_valid, s_flush, s_wen, s_ld;
   bit          s_use [3];
   int unsigned s_addr[3];
   int unsigned s_dst;
   logic [31:0] s_ex, s_mem, s_wb;

   function automatic logic [31:0] rfv(input int unsigned a);
      return 32'(2 * a + 3);
   endfunction

   task automatic apply();
      b3.id_valid_i   = s_valid;
      b3.flush_i      = s_flush;
      b3.id_wen_i     = s_wen;
      b3.id_dst_i     = 5'(s_dst);
      b3.id_is_load_i = s_ld;
      b3.ex_result_i  = s_ex;
      b3.mem_result_i = s_mem;
      b3.wb_data_i    = s_wb;
      for (int k = 0; k < 3; k++) begin
         b3.rd_use_i[k]            = s_use[k];
         b3.rd_addr_i[k*5 +: 5]    = 5'(s_addr[k]);
         b3.rf_data_i[k*32 +: 32]  = rfv(s_addr[k]);
      end
   endtask

   // ---------------- reference model ----------------
   // pipe[d][age]: instruction issued 'age' cycles ago (0 = now in EX).
   typedef struct { bit wen; int unsigned dst; bit ld; } instr_t;
   instr_t      pipe [2][3];
   logic [31:0] m_op [2][3];
   bit          m_opv[2];

   function automatic int nports(input int d);
      return (d == 0) ? 3 : 2;
   endfunction

   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         m_opv[d] = 1'b0;
         for (int i = 0; i < 3; i++) begin
            pipe[d][i].wen = 1'b0; pipe[d][i].dst = 0; pipe[d][i].ld = 1'b0;
            m_op[d][i] = '0;
         end
      end
   endtask

   function automatic bit m_stall(input int d);
      if (!s_valid || s_flush) return 1'b0;
      for (int k = 0; k < nports(d); k++)
         if (s_use[k] && s_addr[k] != 0 && pipe[d][0].wen && pipe[d][0].ld &&
             pipe[d][0].dst == s_addr[k]) return 1'b1;
      return 1'b0;
   endfunction

   // Youngest in-flight writer of the register supplies the value; a load
   // still in EX has no data yet and is passed over.
   function automatic logic [31:0] m_res(input int d, input int k);
      logic [31:0] v[3];
      v[0] = s_ex; v[1] = s_mem; v[2] = s_wb;
      if (s_addr[k] == 0) return '0;
      for (int age = 0; age < 3; age++) begin
         if (pipe[d][age].wen && pipe[d][age].dst == s_addr[k]) begin
            if (age == 0 && pipe[d][age].ld) continue;
            return v[age];
         end
      end
      return rfv(s_addr[k]);
   endfunction

   task automatic m_step(input int d);
      bit iss;
      iss = s_valid && !s_flush && !m_stall(d);
      if (iss)
         for (int k = 0; k < nports(d); k++) m_op[d][k] = m_res(d, k);
      m_opv[d] = iss;
      pipe[d][2] = pipe[d][1];
      pipe[d][1] = pipe[d][0];
      pipe[d][0].wen = iss && s_wen;
      pipe[d][0].dst = iss ? s_dst : 0;
      pipe[d][0].ld  = iss && s_ld;
   endtask

   function automatic logic [95:0] m_pack(input int d);
      logic [95:0] r;
      r = '0;
      for (int k = 0; k < nports(d); k++) r[k*32 +: 32] = m_op[d][k];
      return r;
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      bit          valid, flush;
      logic [2:0]  rd_use;
      int unsigned a0, a1, a2;
      bit          wen;
      int unsigned dst;
      bit          ld;
      logic [31:0] ex, mem, wb;
      bit          exp_stall, exp_opv;
      logic [95:0] exp_op;
   } vec_t;

   function automatic vec_t mkv(
      input bit valid, input bit flush, input logic [2:0] rd_use,
      input int unsigned a0, input int unsigned a1, input int unsigned a2,
      input bit wen, input int unsigned dst, input bit ld,
      input logic [31:0] ex, input logic [31:0] mem, input logic [31:0] wb,
      input bit est, input bit eopv,
      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
      vec_t v;
      v.valid = valid; v.flush = flush; v.rd_use = rd_use;
      v.a0 = a0; v.a1 = a1; v.a2 = a2;
      v.wen = wen; v.dst = dst; v.ld = ld;
      v.ex = ex; v.mem = mem; v.wb = wb;
      v.exp_stall = est; v.exp_opv = eopv;
      v.exp_op = {e2, e1, e0};
      return v;
   endfunction

   task automatic load_vec(input vec_t v);
      s_valid = v.valid; s_flush = v.flush;
      for (int k = 0; k < 3; k++) s_use[k] = v.rd_use[k];
      s_addr[0] = v.a0; s_addr[1] = v.a1; s_addr[2] = v.a2;
      s_wen = v.wen; s_dst = v.dst; s_ld = v.ld;
      s_ex = v.ex; s_mem = v.mem; s_wb = v.wb;
      apply();
   endtask

   task automatic step_vec(input vec_t v, input int idx);
      load_vec(v);
      #2;
      chk($sformatf("stall3[%0d]", idx), 96'(b3.stall_o), 96'(v.exp_stall));
      chk($sformatf("stall2[%0d]", idx), 96'(b2.stall_o), 96'(v.exp_stall));
      @(posedge clk);
      #1;
      chk($sformatf("op3[%0d]", idx), b3.op_o, v.exp_op);
      chk($sformatf("opv3[%0d]", idx), 96'(b3.op_valid_o), 96'(v.exp_opv));
      chk($sformatf("op2[%0d]", idx), 96'(b2.op_o), {32'h0, v.exp_op[63:0]});
      chk($sformatf("opv2[%0d]", idx), 96'(b2.op_valid_o), 96'(v.exp_opv));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_op3"},    b3.op_o, '0);
      chk({tag, "_op2"},    96'(b2.op_o), '0);
      chk({tag, "_opv3"},   96'(b3.op_valid_o), '0);
      chk({tag, "_opv2"},   96'(b2.op_valid_o), '0);
      chk({tag, "_stall3"}, 96'(b3.stall_o), '0);
      chk({tag, "_stall2"}, 96'(b2.stall_o), '0);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      s_valid = 1'b0; s_flush = 1'b0;
      apply();
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state(tag);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[19];
   vec_t v_ld, v_after;

   initial begin
      for (int k = 0; k < 3; k++) begin s_use[k] = 1'b0; s_addr[k] = 0; end
      s_wen = 0; s_dst = 0; s_ld = 0; s_ex = '0; s_mem = '0; s_wb = '0;

      //            v f use   a0 a1 a2  w dst ld  ex            mem           wb            st ov  e0            e1       e2
      vecs[0]  = mkv(1,0,3'b011, 1, 2, 0, 1, 3, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'd5,        32'd7,   32'd0);
      vecs[1]  = mkv(1,0,3'b011, 1, 1, 0, 1, 4, 0, 32'hAA,       32'h0,        32'h0,        0, 1, 32'd5,        32'd5,   32'd0);
      vecs[2]  = mkv(1,0,3'b011, 2, 2, 0, 1, 4, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'd7,        32'd7,   32'd0);
      vecs[3]  = mkv(1,0,3'b011, 1, 2, 0, 1, 4, 0, 32'h0,        32'h0,        32'h0,        0, 1, 32'd5,        32'd7,   32'd0);
      vecs[4]  = mkv(1,0,3'b111, 4, 1, 4, 1, 5, 0, 32'h11,       32'h22,       32'h33,       0, 1, 32'h11,       32'd5,   32'h11);
      vecs[5]  = mkv(1,0,3'b111, 4, 4, 4, 0, 0, 0, 32'h44,       32'h22,       32'h33,       0, 1, 32'h22,       32'h22,  32'h22);
      vecs[6]  = mkv(1,0,3'b111, 4, 5, 3, 0, 0, 0, 32'h55,       32'h66,       32'h77,       0, 1, 32'h77,       32'h66,  32'd9);
      vecs[7]  = mkv(1,0,3'b001, 1, 0, 0, 1, 6, 1, 32'h0,        32'h0,        32'h0,        0, 1, 32'd5,        32'd0,   32'd0);
      vecs[8]  = mkv(1,0,3'b011, 6, 2, 0, 1, 7, 0, 32'h0,        32'h0,        32'h0,        1, 0, 32'd5,        32'd0,   32'd0);
      vecs[9]  = mkv(1,0,3'b011, 6, 2, 0, 1, 7, 0, 32'h1,        32'hDEAD,     32'h2,        0, 1, 32'hDEAD,     32'd7,   32'd0);
      vecs[10] = mkv(1,0,3'b001, 1, 0, 0, 1, 0, 1, 32'h0,        32'h0,        32'h0,        0, 1, 32'd5,        32'd0,   32'd0);
      vecs[11] = mkv(1,0,3'b111, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32'd0,        32'd0,   32'd0);
      vecs[12] = mkv(1,0,3'b111, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 32'd0,        32'd0,   32'd0);
      vecs[13] = mkv(1,0,3'b001, 2, 0, 0, 1, 6, 1, 32'h0,        32'h0,        32'h0,        0, 1, 32'd7,        32'd0,   32'd0);
      vecs[14] = mkv(1,1,3'b001, 6, 0, 0, 1, 8, 0, 32'h0,        32'h0,        32'h0,        0, 0, 32'd7,        32'd0,   32'd0);
      vecs[15] = mkv(1,0,3'b011, 6, 6, 1, 0, 0, 0, 32'h1234,     32'hBEEF,     32'h5,        0, 1, 32'hBEEF,     32'hBEEF, 32'd5);
      vecs[16] = mkv(1,0,3'b001, 1, 0, 0, 1, 9, 1, 32'h0,        32'h0,        32'h0,        0, 1, 32'd5,        32'd0,   32'd0);
      vecs[17] = mkv(1,0,3'b010, 9, 1, 9, 0, 0, 0, 32'h99,       32'h88,       32'h77,       0, 1, 32'h15,       32'd5,   32'h15);
      vecs[18] = mkv(0,0,3'b111, 1, 2, 3, 1,10, 0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h15,       32'd5,   32'h15);

      v_ld    = mkv(1,0,3'b001, 1, 0, 0, 1, 6, 1, 32'h0,    32'h0,    32'h0,    0, 1, 32'd5,  32'd0, 32'd0);
      v_after = mkv(1,0,3'b001, 6, 0, 0, 0, 0, 0, 32'hAAAA, 32'hBBBB, 32'hCCCC, 0, 1, 32'd15, 32'd0, 32'd0);

      do_reset("rst0");

      for (int i = 0; i < 19; i++) step_vec(vecs[i], i);

      // Async reset asserted between edges while a load-use stall is up
      step_vec(v_ld, 100);
      s_valid = 1; s_flush = 0; s_use[0] = 1; s_use[1] = 0; s_use[2] = 0;
      s_addr[0] = 6; s_addr[1] = 0; s_addr[2] = 0; s_wen = 0; s_dst = 0; s_ld = 0;
      apply();
      #2;
      chk("midstall_stall3", 96'(b3.stall_o), 96'(1));
      chk("midstall_stall2", 96'(b2.stall_o), 96'(1));
      #1 rst_n = 1'b0;
      #1;
      chk_reset_state("async");
      s_valid = 0;
      apply();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step_vec(v_after, 101);

      // Random traffic against the model
      do_reset("rst1");
      for (int n = 0; n < 500; n++) begin
         s_valid = ($urandom_range(0, 9) != 0);
         s_flush = ($urandom_range(0, 9) == 0);
         for (int k = 0; k < 3; k++) begin
            s_use[k]  = 1'($urandom_range(0, 1));
            s_addr[k] = $urandom_range(0, 7);
         end
         s_wen = 1'($urandom_range(0, 1));
         s_dst = $urandom_range(0, 7);
         s_ld  = ($urandom_range(0, 2) == 0);
         s_ex  = $urandom; s_mem = $urandom; s_wb = $urandom;
         apply();
         #2;
         chk("rnd_stall3", 96'(b3.stall_o), 96'(m_stall(0)));
         chk("rnd_stall2", 96'(b2.stall_o), 96'(m_stall(1)));
         m_step(0);
         m_step(1);
         @(posedge clk);
         #1;
         chk("rnd_op3",  b3.op_o, m_pack(0));
         chk("rnd_opv3", 96'(b3.op_valid_o), 96'(m_opv[0]));
         chk("rnd_op2",  96'(b2.op_o), m_pack(1));
         chk("rnd_opv2", 96'(b2.op_valid_o), 96'(m_opv[1]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
